// File: rtl/store_processing_unit_pkg.sv
// Shared load/store definitions: FUNC3 codes, store FSM state encoding and byte-lane masks.
package store_processing_unit_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BEAT0 = 2'd1,
    ST_BEAT1 = 2'd2,
    ST_ERR   = 2'd3
  } store_state_e;

  localparam logic [3:0] BASE_MASK_B = 4'b0001;
  localparam logic [3:0] BASE_MASK_H = 4'b0011;
  localparam logic [3:0] BASE_MASK_W = 4'b1111;

  // Expand a per-byte mask into a per-bit mask over one word.
  function automatic logic [XLEN-1:0] byte_to_bit_mask(input logic [3:0] base);
    logic [XLEN-1:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{base[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational store lane alignment: sized data and byte mask shifted into a two-word window.
module store_lane_align
  import store_processing_unit_pkg::*;
(
  input  logic [2:0]      func3_i,
  input  logic [1:0]      off_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [63:0]     data64_c_o,
  output logic [7:0]      mask8_c_o,
  output logic            valid_c_o
);

  logic [3:0] base_c;

  always_comb begin
    base_c    = 4'b0000;
    valid_c_o = 1'b1;
    case (func3_i)
      F3_SB:   base_c = BASE_MASK_B;
      F3_SH:   base_c = BASE_MASK_H;
      F3_SW:   base_c = BASE_MASK_W;
      default: valid_c_o = 1'b0;
    endcase
    mask8_c_o  = 8'({4'b0000, base_c} << off_i);
    data64_c_o = 64'({32'b0, wdata_i & byte_to_bit_mask(base_c)} << {off_i, 3'b000});
  end

endmodule

// File: rtl/store_processing_unit.sv
// Store processing unit: aligns a store and issues one or two word-write beats with a ready handshake.
// Optional STORE_MISALIGN_TRAP_EN: misaligned SH/SW trap via MISALIGNED instead of being split.
module store_processing_unit
  import store_processing_unit_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ_VALID,
  output logic                  REQ_READY,
  input  logic [2:0]            FUNC3,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITE_DATA,
  output logic                  MEM_WRITE_EN,
  output logic [ADDR_WIDTH-1:0] MEM_ADDRESS,
  output logic [DATA_WIDTH-1:0] MEM_WRITE_DATA,
  output logic [3:0]            MEM_BYTE_EN,
  input  logic                  MEM_READY,
  output logic                  DONE,
  output logic                  ERROR
`ifdef STORE_MISALIGN_TRAP_EN
  ,
  output logic                  MISALIGNED
`endif
);

  store_state_e state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] hi_addr_q, hi_addr_d;
  logic [XLEN-1:0]       hi_data_q, hi_data_d;
  logic [3:0]            hi_mask_q, hi_mask_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef STORE_MISALIGN_TRAP_EN
  logic                  misal_q, misal_d;
`endif

  logic [1:0]            off_c;
  logic [ADDR_WIDTH-1:0] word_addr_c;
  logic [63:0]           data64_c;
  logic [7:0]            mask8_c;
  logic                  f3_valid_c;
  logic                  misaligned_c;
  logic                  accept_c;

  assign off_c       = ADDRESS[1:0];
  assign word_addr_c = {ADDRESS[ADDR_WIDTH-1:2], 2'b00};
  assign accept_c    = REQ_VALID & ready_q;

`ifdef STORE_MISALIGN_TRAP_EN
  assign misaligned_c = ((FUNC3 == F3_SH) && off_c[0]) ||
                        ((FUNC3 == F3_SW) && (off_c != 2'b00));
`else
  assign misaligned_c = 1'b0;
`endif

  store_lane_align u_align (
    .func3_i    (FUNC3),
    .off_i      (off_c),
    .wdata_i    (WRITE_DATA),
    .data64_c_o (data64_c),
    .mask8_c_o  (mask8_c),
    .valid_c_o  (f3_valid_c)
  );

  // Next state and next registered outputs; beat outputs hold until MEM_READY.
  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    hi_addr_d = hi_addr_q;
    hi_data_d = hi_data_q;
    hi_mask_d = hi_mask_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    misal_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (!f3_valid_c || misaligned_c) begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            error_d = ~f3_valid_c;
`ifdef STORE_MISALIGN_TRAP_EN
            misal_d = misaligned_c;
`endif
          end else begin
            state_d   = ST_BEAT0;
            we_d      = 1'b1;
            addr_d    = word_addr_c;
            wdata_d   = data64_c[31:0];
            be_d      = mask8_c[3:0];
            hi_addr_d = ADDR_WIDTH'(word_addr_c + ADDR_WIDTH'(WORD_BYTES));
            hi_data_d = data64_c[63:32];
            hi_mask_d = mask8_c[7:4];
          end
        end
      end
      ST_BEAT0: begin
        if (MEM_READY) begin
          if (hi_mask_q == 4'b0000) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            we_d    = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
            be_d    = '0;
          end else begin
            state_d = ST_BEAT1;
            addr_d  = hi_addr_q;
            wdata_d = hi_data_q;
            be_d    = hi_mask_q;
          end
        end
      end
      ST_BEAT1: begin
        if (MEM_READY) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          we_d    = 1'b0;
          addr_d  = '0;
          wdata_d = '0;
          be_d    = '0;
        end
      end
      ST_ERR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      hi_addr_q <= '0;
      hi_data_q <= '0;
      hi_mask_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
      misal_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      hi_addr_q <= hi_addr_d;
      hi_data_q <= hi_data_d;
      hi_mask_q <= hi_mask_d;
      done_q    <= done_d;
      error_q   <= error_d;
`ifdef STORE_MISALIGN_TRAP_EN
      misal_q   <= misal_d;
`endif
    end
  end

  assign REQ_READY      = ready_q;
  assign MEM_WRITE_EN   = we_q;
  assign MEM_ADDRESS    = addr_q;
  assign MEM_WRITE_DATA = wdata_q;
  assign MEM_BYTE_EN    = be_q;
  assign DONE           = done_q;
  assign ERROR          = error_q;
`ifdef STORE_MISALIGN_TRAP_EN
  assign MISALIGNED     = misal_q;
`endif

endmodule

// File: tb/tb_store_processing_unit.sv
// Self-checking bench for store_processing_unit: directed cases plus random stores against a byte-level model.
module tb_store_processing_unit;

  logic        CLK;
  logic        RESET;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  FUNC3;
  logic [31:0] ADDRESS;
  logic [31:0] WRITE_DATA;
  logic        MEM_WRITE_EN;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WRITE_DATA;
  logic [3:0]  MEM_BYTE_EN;
  logic        MEM_READY;
  logic        DONE;
  logic        ERROR;
`ifdef STORE_MISALIGN_TRAP_EN
  logic        MISALIGNED;
`endif

  int checks = 0;
  int errors = 0;

  store_processing_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .REQ_VALID      (REQ_VALID),
    .REQ_READY      (REQ_READY),
    .FUNC3          (FUNC3),
    .ADDRESS        (ADDRESS),
    .WRITE_DATA     (WRITE_DATA),
    .MEM_WRITE_EN   (MEM_WRITE_EN),
    .MEM_ADDRESS    (MEM_ADDRESS),
    .MEM_WRITE_DATA (MEM_WRITE_DATA),
    .MEM_BYTE_EN    (MEM_BYTE_EN),
    .MEM_READY      (MEM_READY),
    .DONE           (DONE),
    .ERROR          (ERROR)
`ifdef STORE_MISALIGN_TRAP_EN
    ,
    .MISALIGNED     (MISALIGNED)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".we"},   32'(MEM_WRITE_EN),  32'd0);
    check({tag, ".addr"}, MEM_ADDRESS,        32'd0);
    check({tag, ".data"}, MEM_WRITE_DATA,     32'd0);
    check({tag, ".be"},   32'(MEM_BYTE_EN),   32'd0);
  endtask

  // Model: place each stored byte at its own byte address, grouping bytes by word into beats.
  task automatic run_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] d, input int stall_max);
    int          nbytes;
    bit          bad_f3;
    bit          mis;
    beat_t       beats[$];
    beat_t       bt;
    bit          open;
    logic [31:0] b;
    logic [31:0] w;
    int          lane;
    int          stall;

    case (f3)
      3'b000:  nbytes = 1;
      3'b001:  nbytes = 2;
      3'b010:  nbytes = 4;
      default: nbytes = 0;
    endcase
    bad_f3 = (nbytes == 0);
    mis    = 1'b0;
`ifdef STORE_MISALIGN_TRAP_EN
    if (nbytes > 1) mis = ((a & 32'(nbytes - 1)) != 32'd0);
`endif
    open = 1'b0;
    if (!bad_f3 && !mis) begin
      for (int i = 0; i < nbytes; i++) begin
        b    = a + 32'(i);
        w    = b & 32'hFFFF_FFFC;
        lane = int'(b & 32'd3);
        if (!open || bt.addr != w) begin
          if (open) beats.push_back(bt);
          bt.addr = w;
          bt.data = '0;
          bt.be   = '0;
          open    = 1'b1;
        end
        bt.data[lane*8 +: 8] = d[i*8 +: 8];
        bt.be[lane]          = 1'b1;
      end
      beats.push_back(bt);
    end

    check({tag, ".req_ready"}, 32'(REQ_READY), 32'd1);
    REQ_VALID  = 1'b1;
    FUNC3      = f3;
    ADDRESS    = a;
    WRITE_DATA = d;
    MEM_READY  = 1'b0;
    @(negedge CLK);
    REQ_VALID  = 1'b0;
    FUNC3      = 3'($urandom);
    ADDRESS    = $urandom;
    WRITE_DATA = $urandom;

    if (bad_f3 || mis) begin
      check({tag, ".err_done"},  32'(DONE),         32'd1);
      check({tag, ".err_error"}, 32'(ERROR),        32'(bad_f3));
      check({tag, ".err_we"},    32'(MEM_WRITE_EN), 32'd0);
      check({tag, ".err_ready"}, 32'(REQ_READY),    32'd0);
`ifdef STORE_MISALIGN_TRAP_EN
      check({tag, ".err_misal"}, 32'(MISALIGNED),   32'(mis));
`endif
      @(negedge CLK);
      check({tag, ".post_done"}, 32'(DONE),      32'd0);
      check({tag, ".post_rdy"},  32'(REQ_READY), 32'd1);
      return;
    end

    foreach (beats[k]) begin
      stall = (stall_max > 0) ? int'($urandom_range(0, stall_max)) : 0;
      for (int s = 0; s <= stall; s++) begin
        check({tag, $sformatf(".b%0d.we", k)},   32'(MEM_WRITE_EN), 32'd1);
        check({tag, $sformatf(".b%0d.addr", k)}, MEM_ADDRESS,       beats[k].addr);
        check({tag, $sformatf(".b%0d.data", k)}, MEM_WRITE_DATA,    beats[k].data);
        check({tag, $sformatf(".b%0d.be", k)},   32'(MEM_BYTE_EN),  32'(beats[k].be));
        check({tag, $sformatf(".b%0d.rdy", k)},  32'(REQ_READY),    32'd0);
        check({tag, $sformatf(".b%0d.done", k)}, 32'(DONE),         32'd0);
        MEM_READY = (s == stall);
        @(negedge CLK);
      end
    end
    MEM_READY = 1'b0;
    check({tag, ".done"},      32'(DONE),      32'd1);
    check({tag, ".done_err"},  32'(ERROR),     32'd0);
    check({tag, ".done_rdy"},  32'(REQ_READY), 32'd1);
    check_idle_outputs({tag, ".done"});
  endtask

  initial begin
    CLK        = 1'b0;
    RESET      = 1'b1;
    REQ_VALID  = 1'b0;
    FUNC3      = 3'b000;
    ADDRESS    = '0;
    WRITE_DATA = '0;
    MEM_READY  = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst.ready", 32'(REQ_READY), 32'd0);
    check("rst.done",  32'(DONE),      32'd0);
    check("rst.error", 32'(ERROR),     32'd0);
    check_idle_outputs("rst");
    RESET = 1'b0;
    @(negedge CLK);
    check("rst_rel.ready", 32'(REQ_READY), 32'd1);

    // Directed cases from the test plan
    run_store("sb_103",   3'b000, 32'h0000_0103, 32'hDEAD_BEEF, 0);
    run_store("sw_202",   3'b010, 32'h0000_0202, 32'h1122_3344, 0);
    // SH with three stall cycles
    begin
      check("sh_40.req_ready", 32'(REQ_READY), 32'd1);
      REQ_VALID = 1'b1; FUNC3 = 3'b001; ADDRESS = 32'h40; WRITE_DATA = 32'hAAAA_5678;
      @(negedge CLK);
      REQ_VALID = 1'b0;
      for (int s = 0; s < 4; s++) begin
        check("sh_40.we",   32'(MEM_WRITE_EN),  32'd1);
        check("sh_40.addr", MEM_ADDRESS,        32'h0000_0040);
        check("sh_40.data", MEM_WRITE_DATA,     32'h0000_5678);
        check("sh_40.be",   32'(MEM_BYTE_EN),   32'h3);
        check("sh_40.rdy",  32'(REQ_READY),     32'd0);
        MEM_READY = (s == 3);
        @(negedge CLK);
      end
      MEM_READY = 1'b0;
      check("sh_40.done", 32'(DONE), 32'd1);
      check_idle_outputs("sh_40.done");
    end
    run_store("bad_f3",   3'b011, 32'h0000_0010, 32'h1234_5678, 0);
    run_store("sw_wrap",  3'b010, 32'hFFFF_FFFF, 32'hCAFE_F00D, 1);
    run_store("sh_odd",   3'b001, 32'h0000_0083, 32'h0000_BEEF, 2);
    run_store("sh_off1",  3'b001, 32'h0000_0081, 32'h0000_1234, 0);
    run_store("bad_f3_7", 3'b111, 32'h0000_0000, 32'hFFFF_FFFF, 0);

    // Reset during the second beat of a split store
    begin
      REQ_VALID = 1'b1; FUNC3 = 3'b010; ADDRESS = 32'h0000_0202; WRITE_DATA = 32'h1122_3344;
      @(negedge CLK);
      REQ_VALID = 1'b0;
      MEM_READY = 1'b1;
      @(negedge CLK);
      check("rst_mid.b1_addr", MEM_ADDRESS, 32'h0000_0204);
      MEM_READY = 1'b0;
      RESET     = 1'b1;
      @(negedge CLK);
      check("rst_mid.we",    32'(MEM_WRITE_EN), 32'd0);
      check("rst_mid.ready", 32'(REQ_READY),    32'd0);
      check("rst_mid.done",  32'(DONE),         32'd0);
      @(negedge CLK);
      check("rst_mid.hold_ready", 32'(REQ_READY), 32'd0);
      RESET = 1'b0;
      @(negedge CLK);
      check("rst_mid.rel_ready", 32'(REQ_READY), 32'd1);
      check("rst_mid.rel_done",  32'(DONE),      32'd0);
      check_idle_outputs("rst_mid.rel");
    end

    // Random stores, back-to-back through the DONE cycle
    for (int n = 0; n < 60; n++) begin
      logic [2:0]  f3;
      logic [31:0] a;
      int          pick;
      pick = int'($urandom_range(0, 9));
      f3   = (pick < 3) ? 3'b000 : (pick < 6) ? 3'b001 : (pick < 9) ? 3'b010
                                                                      : 3'(3 + $urandom_range(0, 4));
      a    = $urandom;
      if ($urandom_range(0, 5) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
      run_store($sformatf("rnd%0d", n), f3, a, $urandom, 2);
    end

    @(negedge CLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
